// File: rtl/drive_select_driver_pkg.sv
// Shared types and constants for the RK05 drive-select bus generator.
// State encodings and bus idle/mode values used by the driver and the bench.
package drive_select_driver_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESELECT,
        S_ASSERT,
        S_WAIT_RESP,
        S_HOLD
    } state_t;

    localparam logic [3:0] SEL_IDLE    = 4'b1111;
    localparam logic       MODE_RK11D  = 1'b1;
    localparam logic       MODE_ONEHOT = 1'b0;

endpackage

// File: rtl/drive_select_driver_sync.sv
// Two-flop synchronizer for asynchronous bus inputs.
// The reset value lets active-low inputs come up in their inactive state.
module drive_select_driver_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/drive_select_driver.sv
// Tester-side RK05 drive-select sequencer: break-before-make, settle,
// then wait for the selected drive's synchronized ready response.
module drive_select_driver
    import drive_select_driver_pkg::*;
#(
    parameter int SETTLE_CLKS  = 8,
    parameter int TIMEOUT_CLKS = 20000,
    parameter int CNT_W        = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sel_req,
    input  logic [2:0] req_addr,
    input  logic       rk11d_mode,
    input  logic       release_req,
    input  logic       BUS_FILE_READY_L,
    output logic       BUS_RK11D_L,
    output logic [3:0] BUS_SEL_DR_L,
    output logic       busy,
    output logic       sel_done,
    output logic       sel_timeout,
    output logic       sel_error,
    output logic [2:0] selected_addr
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CLKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       sel_n;
    logic             rk_n, mode, mode_n;
    logic [2:0]       addr_n;
    logic             done_n, timeout_n, error_n;
    logic             ready_l;

    function automatic logic [3:0] encode(input logic m, input logic [2:0] a);
        if (m == MODE_RK11D) return {1'b1, ~a};
        return ~(4'b0001 << a[1:0]);
    endfunction

    drive_select_driver_sync #(.RST_VAL(1'b1)) u_ready_sync (
        .clock (clock),
        .reset (reset),
        .d     (BUS_FILE_READY_L),
        .q     (ready_l)
    );

    assign busy = (state == S_DESELECT) || (state == S_ASSERT)
               || (state == S_WAIT_RESP);

    always_comb begin
        state_n   = state;
        cnt_n     = (cnt == '1) ? cnt : cnt + 1'b1;
        sel_n     = BUS_SEL_DR_L;
        rk_n      = BUS_RK11D_L;
        addr_n    = selected_addr;
        mode_n    = mode;
        done_n    = 1'b0;
        timeout_n = 1'b0;
        error_n   = 1'b0;
        if (release_req) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            sel_n   = SEL_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_HOLD: begin
                    if (sel_req) begin
                        // A rejected request leaves any held selection untouched
                        if (rk11d_mode == MODE_ONEHOT && req_addr[2]) begin
                            error_n = 1'b1;
                        end else begin
                            state_n = S_DESELECT;
                            cnt_n   = '0;
                            sel_n   = SEL_IDLE;
                            rk_n    = ~rk11d_mode;
                            addr_n  = req_addr;
                            mode_n  = rk11d_mode;
                        end
                    end
                end
                S_DESELECT: begin
                    if (cnt == SETTLE_LAST) begin
                        state_n = S_ASSERT;
                        cnt_n   = '0;
                        sel_n   = encode(mode, selected_addr);
                    end
                end
                S_ASSERT: begin
                    if (cnt == SETTLE_LAST) begin
                        state_n = S_WAIT_RESP;
                        cnt_n   = '0;
                    end
                end
                S_WAIT_RESP: begin
                    if (!ready_l) begin
                        state_n = S_HOLD;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_n   = S_IDLE;
                        cnt_n     = '0;
                        sel_n     = SEL_IDLE;
                        timeout_n = 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    sel_n   = SEL_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            BUS_SEL_DR_L  <= SEL_IDLE;
            BUS_RK11D_L   <= 1'b1;
            selected_addr <= '0;
            mode          <= MODE_ONEHOT;
            sel_done      <= 1'b0;
            sel_timeout   <= 1'b0;
            sel_error     <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            BUS_SEL_DR_L  <= sel_n;
            BUS_RK11D_L   <= rk_n;
            selected_addr <= addr_n;
            mode          <= mode_n;
            sel_done      <= done_n;
            sel_timeout   <= timeout_n;
            sel_error     <= error_n;
        end
    end

endmodule

// File: tb/tb_drive_select_driver.sv
// Scenario bench for drive_select_driver: expected bus events are queued
// when a request is issued and popped when the DUT pulses done/timeout/error.
module tb_drive_select_driver;

    localparam int TO = 20000;

    logic       clock = 1'b0;
    logic       reset, sel_req, rk11d_mode, release_req, ready_l;
    logic [2:0] req_addr;
    logic       BUS_RK11D_L, busy, sel_done, sel_timeout, sel_error;
    logic [3:0] BUS_SEL_DR_L;
    logic [2:0] selected_addr;

    typedef struct {
        int         kind;
        logic [3:0] sel;
        logic       rk;
        logic [2:0] addr;
        int         cycles;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0, n_bad = 0;
    int  n_pulse = 0;

    drive_select_driver dut (
        .clock            (clock),
        .reset            (reset),
        .sel_req          (sel_req),
        .req_addr         (req_addr),
        .rk11d_mode       (rk11d_mode),
        .release_req      (release_req),
        .BUS_FILE_READY_L (ready_l),
        .BUS_RK11D_L      (BUS_RK11D_L),
        .BUS_SEL_DR_L     (BUS_SEL_DR_L),
        .busy             (busy),
        .sel_done         (sel_done),
        .sel_timeout      (sel_timeout),
        .sel_error        (sel_error),
        .selected_addr    (selected_addr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        n_pulse += int'(sel_done) + int'(sel_timeout) + int'(sel_error);
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic req(input logic [2:0] a, input logic m);
        @(negedge clock);
        sel_req = 1'b1; req_addr = a; rk11d_mode = m;
        @(negedge clock);
        sel_req = 1'b0;
    endtask

    task automatic rel();
        @(negedge clock);
        release_req = 1'b1;
        @(negedge clock);
        release_req = 1'b0;
    endtask

    task automatic wait_event(input int limit, output ev_t got);
        bit found = 0;
        got = '{kind: 0, sel: 4'hx, rk: 1'bx, addr: 3'hx, cycles: limit};
        for (int k = 0; k <= limit && !found; k++) begin
            if (sel_done || sel_timeout || sel_error) begin
                found = 1;
                got.kind   = sel_done ? 1 : (sel_timeout ? 2 : 3);
                got.sel    = BUS_SEL_DR_L;
                got.rk     = BUS_RK11D_L;
                got.addr   = selected_addr;
                got.cycles = k;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sel_req = 0; release_req = 0;
        req_addr = 0; rk11d_mode = 0; ready_l = 1'b1;
        settle(3);
        n_cmp++;
        if ({BUS_SEL_DR_L, BUS_RK11D_L, busy, selected_addr} !== 9'b1111_1_0_000
            || {sel_done, sel_timeout, sel_error} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset: sel=%b rk=%b busy=%b addr=%0d pulses=%b want 1111/1/0/0/000",
                     BUS_SEL_DR_L, BUS_RK11D_L, busy, selected_addr,
                     {sel_done, sel_timeout, sel_error});
        end
        @(negedge clock);
        reset = 1'b0;
        settle(2);
    endtask

    task automatic test_rk11d_select();
        ev_t got, e;
        int p0;
        exp_q.push_back('{kind: 1, sel: 4'b1010, rk: 1'b0, addr: 3'd5, cycles: 3});
        req(3'd5, 1'b1);
        n_cmp++;
        if ({BUS_SEL_DR_L, BUS_RK11D_L, busy} !== 6'b1111_0_1) begin
            n_bad++;
            $display("FAIL rk_deselect: sel=%b rk=%b busy=%b want 1111/0/1",
                     BUS_SEL_DR_L, BUS_RK11D_L, busy);
        end
        settle(20);
        ready_l = 1'b0;
        wait_event(10, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got.kind != e.kind || got.cycles != e.cycles) begin
            n_bad++;
            $display("FAIL rk_event: kind/cycles %0d/%0d want %0d/%0d",
                     got.kind, got.cycles, e.kind, e.cycles);
        end
        n_cmp++;
        if ({got.sel, got.rk, got.addr} !== {e.sel, e.rk, e.addr}) begin
            n_bad++;
            $display("FAIL rk_bus: sel/rk/addr %b/%b/%0d want %b/%b/%0d",
                     got.sel, got.rk, got.addr, e.sel, e.rk, e.addr);
        end
        p0 = n_pulse;
        settle(10);
        n_cmp++;
        if (n_pulse != p0 || BUS_SEL_DR_L !== 4'b1010 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rk_hold: extra pulses=%0d sel=%b busy=%b want 0/1010/0",
                     n_pulse - p0, BUS_SEL_DR_L, busy);
        end
        ready_l = 1'b1;
        rel();
        n_cmp++;
        if ({BUS_SEL_DR_L, BUS_RK11D_L, busy} !== 6'b1111_0_0) begin
            n_bad++;
            $display("FAIL rk_release: sel=%b rk=%b busy=%b want 1111/0/0",
                     BUS_SEL_DR_L, BUS_RK11D_L, busy);
        end
    endtask

    task automatic test_onehot_select();
        ev_t got, e;
        logic [3:0] want;
        exp_q.push_back('{kind: 1, sel: 4'b1011, rk: 1'b1, addr: 3'd2, cycles: 3});
        exp_q.push_back('{kind: 3, sel: 4'b1011, rk: 1'b1, addr: 3'd2, cycles: 0});
        settle(3);
        req(3'd2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            want = (i < 8) ? 4'b1111 : 4'b1011;
            n_cmp++;
            if (BUS_SEL_DR_L !== want || BUS_RK11D_L !== 1'b1 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL oh_seq[%0d]: sel=%b rk=%b busy=%b want %b/1/1",
                         i, BUS_SEL_DR_L, BUS_RK11D_L, busy, want);
            end
            @(negedge clock);
        end
        ready_l = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (j == 1) req(3'd7, 1'b0);
            wait_event(10, got);
            e = exp_q.pop_front();
            n_cmp++;
            if (got.kind != e.kind || got.cycles != e.cycles
                || {got.sel, got.rk, got.addr} !== {e.sel, e.rk, e.addr}) begin
                n_bad++;
                $display("FAIL oh_event[%0d]: k=%0d c=%0d sel=%b rk=%b a=%0d want k=%0d c=%0d sel=%b rk=%b a=%0d",
                         j, got.kind, got.cycles, got.sel, got.rk, got.addr,
                         e.kind, e.cycles, e.sel, e.rk, e.addr);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || BUS_SEL_DR_L !== 4'b1011) begin
            n_bad++;
            $display("FAIL oh_reject_hold: busy=%b sel=%b want 0/1011", busy, BUS_SEL_DR_L);
        end
        rel();
        ready_l = 1'b1;
    endtask

    task automatic test_reject();
        ev_t got, e;
        int nbusy = 0;
        exp_q.push_back('{kind: 3, sel: 4'b1111, rk: 1'b1, addr: 3'd2, cycles: 0});
        settle(3);
        req(3'd6, 1'b0);
        if (busy !== 1'b0) nbusy++;
        wait_event(3, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got.kind != e.kind || got.cycles != e.cycles || got.sel !== e.sel) begin
            n_bad++;
            $display("FAIL reject_event: k=%0d c=%0d sel=%b want k=%0d c=%0d sel=%b",
                     got.kind, got.cycles, got.sel, e.kind, e.cycles, e.sel);
        end
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0 || BUS_SEL_DR_L !== 4'b1111) nbusy++;
            @(negedge clock);
        end
        n_cmp++;
        if (nbusy != 0) begin
            n_bad++;
            $display("FAIL reject_idle: busy/sel wrong on %0d cycles want 0", nbusy);
        end
    endtask

    task automatic test_timeout();
        ev_t got, e;
        exp_q.push_back('{kind: 2, sel: 4'b1111, rk: 1'b0, addr: 3'd0, cycles: TO});
        req(3'd0, 1'b1);
        settle(16);
        wait_event(TO + 10, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got.kind != e.kind || got.cycles != e.cycles) begin
            n_bad++;
            $display("FAIL timeout_event: kind/cycles %0d/%0d want %0d/%0d",
                     got.kind, got.cycles, e.kind, e.cycles);
        end
        n_cmp++;
        if (got.sel !== e.sel || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_bus: sel=%b busy=%b want %b/0", got.sel, busy, e.sel);
        end
    endtask

    task automatic test_back_to_back();
        ev_t got, e;
        logic [3:0] want;
        int p0;
        exp_q.push_back('{kind: 1, sel: 4'b1110, rk: 1'b0, addr: 3'd1, cycles: 3});
        exp_q.push_back('{kind: 1, sel: 4'b1100, rk: 1'b0, addr: 3'd3, cycles: 1});
        settle(3);
        req(3'd1, 1'b1);
        settle(16);
        ready_l = 1'b0;
        wait_event(10, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got.kind != e.kind || got.cycles != e.cycles
            || {got.sel, got.rk, got.addr} !== {e.sel, e.rk, e.addr}) begin
            n_bad++;
            $display("FAIL b2b_first: k=%0d c=%0d sel=%b a=%0d want k=%0d c=%0d sel=%b a=%0d",
                     got.kind, got.cycles, got.sel, got.addr, e.kind, e.cycles, e.sel, e.addr);
        end
        req(3'd3, 1'b1);
        for (int i = 0; i < 16; i++) begin
            want = (i < 8) ? 4'b1111 : 4'b1100;
            n_cmp++;
            if (BUS_SEL_DR_L !== want) begin
                n_bad++;
                $display("FAIL b2b_seq[%0d]: sel=%b want %b", i, BUS_SEL_DR_L, want);
            end
            @(negedge clock);
        end
        wait_event(5, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got.kind != e.kind || got.cycles != e.cycles
            || {got.sel, got.rk, got.addr} !== {e.sel, e.rk, e.addr}) begin
            n_bad++;
            $display("FAIL b2b_second: k=%0d c=%0d sel=%b a=%0d want k=%0d c=%0d sel=%b a=%0d",
                     got.kind, got.cycles, got.sel, got.addr, e.kind, e.cycles, e.sel, e.addr);
        end
        ready_l = 1'b1;
        p0 = n_pulse;
        settle(10);
        n_cmp++;
        if (n_pulse != p0 || BUS_SEL_DR_L !== 4'b1100 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ready_drop: pulses=%0d sel=%b busy=%b want 0/1100/0",
                     n_pulse - p0, BUS_SEL_DR_L, busy);
        end
        rel();
    endtask

    task automatic test_abort();
        int p0;
        settle(3);
        req(3'd2, 1'b1);
        settle(19);
        @(negedge clock);
        ready_l = 1'b0;
        release_req = 1'b1; sel_req = 1'b1; req_addr = 3'd4;
        @(negedge clock);
        release_req = 1'b0; sel_req = 1'b0;
        p0 = n_pulse;
        n_cmp++;
        if (busy !== 1'b0 || BUS_SEL_DR_L !== 4'b1111) begin
            n_bad++;
            $display("FAIL abort_state: busy=%b sel=%b want 0/1111", busy, BUS_SEL_DR_L);
        end
        settle(30);
        n_cmp++;
        if (n_pulse != p0 || busy !== 1'b0 || BUS_SEL_DR_L !== 4'b1111) begin
            n_bad++;
            $display("FAIL abort_quiet: pulses=%0d busy=%b sel=%b want 0/0/1111",
                     n_pulse - p0, busy, BUS_SEL_DR_L);
        end
        ready_l = 1'b1;
        settle(5);
        req(3'd6, 1'b1);
        settle(10);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({BUS_SEL_DR_L, BUS_RK11D_L, busy, selected_addr} !== 9'b1111_1_0_000) begin
            n_bad++;
            $display("FAIL reset_async: sel=%b rk=%b busy=%b addr=%0d want 1111/1/0/0",
                     BUS_SEL_DR_L, BUS_RK11D_L, busy, selected_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        p0 = n_pulse;
        settle(30);
        n_cmp++;
        if (n_pulse != p0 || busy !== 1'b0 || BUS_SEL_DR_L !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_quiet: pulses=%0d busy=%b sel=%b want 0/0/1111",
                     n_pulse - p0, busy, BUS_SEL_DR_L);
        end
    endtask

    initial begin
        test_reset();
        test_rk11d_select();
        test_onehot_select();
        test_reject();
        test_timeout();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
